// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong reorder of bit-reversed 2-lane FFT output into natural order (optional OVF via FFT_REORDER_OVF_EN)
module fft_bitrev_reorder #(
    parameter int N  = 64,
    parameter int DW = 64
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [DW-1:0] D0,
    input  logic [DW-1:0] D1,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic          OUT_LAST,
    output logic [DW-1:0] Q0,
    output logic [DW-1:0] Q1
`ifdef FFT_REORDER_OVF_EN
    ,
    output logic          OVF
`endif
);

    localparam int LN = $clog2(N);
    localparam int CW = LN - 1;
    localparam logic [CW-1:0] LAST_C = {CW{1'b1}};

    // Reverse the bit order of a full sample index.
    function automatic logic [LN-1:0] bitrev(input logic [LN-1:0] x);
        logic [LN-1:0] r;
        for (int i = 0; i < LN; i++) begin
            r[i] = x[LN-1-i];
        end
        return r;
    endfunction

    logic [DW-1:0] mem_q [0:1][0:N-1];

    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [1:0]    full_q, full_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [DW-1:0] q0_q, q0_d;
    logic [DW-1:0] q1_q, q1_d;
    logic          accept;
    logic          load;
    logic [LN-1:0] wr_idx0;
    logic [LN-1:0] wr_idx1;

    assign IN_READY  = !full_q[wb_q];
    assign OUT_VALID = out_valid_q;
    assign OUT_LAST  = out_last_q;
    assign Q0        = q0_q;
    assign Q1        = q1_q;

    // Next-state for pointers, bank flags and the output pair register.
    always_comb begin
        wb_d        = wb_q;
        rb_d        = rb_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        full_d      = full_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        q0_d        = q0_q;
        q1_d        = q1_q;
        accept      = IN_VALID && !full_q[wb_q];
        load        = full_q[rb_q] && (!out_valid_q || OUT_READY);
        wr_idx0     = bitrev({wcnt_q, 1'b0});
        wr_idx1     = bitrev({wcnt_q, 1'b1});

        if (accept) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == LAST_C) begin
                full_d[wb_q] = 1'b1;
                wb_d         = !wb_q;
            end
        end

        // The read bank is always full and the write bank never is,
        // so the set above and the clear below never touch the same bit.
        if (load) begin
            q0_d        = mem_q[rb_q][{rcnt_q, 1'b0}];
            q1_d        = mem_q[rb_q][{rcnt_q, 1'b1}];
            out_valid_d = 1'b1;
            out_last_d  = (rcnt_q == LAST_C);
            rcnt_d      = rcnt_q + 1'b1;
            if (rcnt_q == LAST_C) begin
                full_d[rb_q] = 1'b0;
                rb_d         = !rb_q;
            end
        end else if (out_valid_q && OUT_READY) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            full_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            q0_q        <= '0;
            q1_q        <= '0;
        end else begin
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
        end
    end

    // Sample storage; contents are meaningless until the bank is marked full.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem_q[wb_q][wr_idx0] <= D0;
            mem_q[wb_q][wr_idx1] <= D1;
        end
    end

`ifdef FFT_REORDER_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky: an upstream beat was offered while the write bank was busy.
    always_comb begin
        ovf_d = ovf_q || (IN_VALID && !IN_READY);
    end

    // Overflow flag register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`endif

endmodule
